// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the decode stage: widths, opcodes, ALU codes,
// control-bit layout and the decoded-instruction record.
package decode_stage_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int VIRT_ADDR_WIDTH = 32;
  localparam int XLEN            = 32;
  localparam int REG_AW          = 5;
  localparam int NUM_REGS        = 32;
  localparam int NUM_RD_PORTS    = 2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // mem_read is the MSB of the 5-bit ctrl bus
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic is_branch;
    logic use_imm;
  } ctrl_t;

  localparam ctrl_t CTRL_OP     = 5'b00100;
  localparam ctrl_t CTRL_OPIMM  = 5'b00101;
  localparam ctrl_t CTRL_LOAD   = 5'b10101;
  localparam ctrl_t CTRL_STORE  = 5'b01001;
  localparam ctrl_t CTRL_BRANCH = 5'b00010;

  typedef struct packed {
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [3:0]        alu_op;
    ctrl_t             ctrl;
    logic              illegal;
    logic              uses_rs2;
  } dec_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch/writeback inputs and execute-side outputs of the decode stage.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic                       wrt_en;
  logic                       flush;
  logic [INST_WIDTH-1:0]      instruction;
  logic [VIRT_ADDR_WIDTH-1:0] PCin;
  logic                       wb_en;
  logic [REG_AW-1:0]          wb_addr;
  logic [XLEN-1:0]            wb_data;

  logic [VIRT_ADDR_WIDTH-1:0] PCnext;
  logic [XLEN-1:0]            rs1_data;
  logic [XLEN-1:0]            rs2_data;
  logic [XLEN-1:0]            imm;
  logic [REG_AW-1:0]          rd;
  logic [3:0]                 alu_op;
  logic [4:0]                 ctrl;
  logic                       valid_out;
  logic                       illegal;
  logic                       stall_fetch;

  modport master (
    output wrt_en, flush, instruction, PCin, wb_en, wb_addr, wb_data,
    input  PCnext, rs1_data, rs2_data, imm, rd, alu_op, ctrl, valid_out, illegal, stall_fetch
  );

  modport slave (
    input  wrt_en, flush, instruction, PCin, wb_en, wb_addr, wb_data,
    output PCnext, rs1_data, rs2_data, imm, rd, alu_op, ctrl, valid_out, illegal, stall_fetch
  );
endinterface

// File: rtl/decode_stage_reg_file.sv
// 32x32 register file: x0 hardwired to zero, combinational reads with
// write-through bypass, one write port.
module reg_file
  import decode_stage_pkg::*;
(
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_RD_PORTS-1:0][REG_AW-1:0]     rd_addr,
  output logic [NUM_RD_PORTS-1:0][XLEN-1:0]       rd_data,
  input  logic                                    wr_en,
  input  logic [REG_AW-1:0]                       wr_addr,
  input  logic [XLEN-1:0]                         wr_data
);

  logic [XLEN-1:0] mem [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // same-cycle writeback is forwarded so decode never sees a stale operand
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    assign rd_data[p] = (rd_addr[p] == '0)                   ? '0      :
                        (wr_en && wr_addr == rd_addr[p])      ? wr_data :
                                                                mem[rd_addr[p]];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decoder, load-use hazard detection and the
// decode/execute stage register, with the register file as a sub-block.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  decode_stage_if.slave bus
);

  logic [INST_WIDTH-1:0]                inst;
  logic [XLEN-1:0]                      imm_i, imm_s, imm_b;
  dec_t                                 dec;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0]    rdata;
  logic                                 load_use;

  logic [VIRT_ADDR_WIDTH-1:0] pc_q;
  logic [XLEN-1:0]            rs1_q, rs2_q, imm_q;
  logic [REG_AW-1:0]          rd_q;
  logic [3:0]                 alu_q;
  ctrl_t                      ctrl_q;
  logic                       valid_q, illegal_q;

  assign inst  = bus.instruction;
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  always_comb begin
    dec     = '0;
    dec.rd  = inst[11:7];
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    case (inst[6:0])
      OPC_OP: begin
        dec.alu_op   = {inst[30], inst[14:12]};
        dec.ctrl     = CTRL_OP;
        dec.uses_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        dec.alu_op = {1'b0, inst[14:12]};
        dec.ctrl   = CTRL_OPIMM;
        dec.imm    = imm_i;
      end
      OPC_LOAD: begin
        dec.alu_op = ALU_ADD;
        dec.ctrl   = CTRL_LOAD;
        dec.imm    = imm_i;
      end
      OPC_STORE: begin
        dec.alu_op   = ALU_ADD;
        dec.ctrl     = CTRL_STORE;
        dec.imm      = imm_s;
        dec.uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        // only BEQ/BNE are implemented; other compares are unsupported
        if (inst[14:13] == 2'b00) begin
          dec.alu_op   = ALU_SUB;
          dec.ctrl     = CTRL_BRANCH;
          dec.imm      = imm_b;
          dec.uses_rs2 = 1'b1;
        end else begin
          dec.illegal = 1'b1;
          dec.rd      = '0;
        end
      end
      default: begin
        dec.illegal = 1'b1;
        dec.rd      = '0;
      end
    endcase
  end

  reg_file u_rf (
    .clk     (clk),
    .reset   (reset),
    .rd_addr ({dec.rs2, dec.rs1}),
    .rd_data (rdata),
    .wr_en   (bus.wb_en),
    .wr_addr (bus.wb_addr),
    .wr_data (bus.wb_data)
  );

  // hazard is judged against the instruction currently held for execute
  assign load_use = valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                    ((rd_q == dec.rs1) || (dec.uses_rs2 && rd_q == dec.rs2));
  assign bus.stall_fetch = load_use && !(bus.flush && bus.wrt_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (bus.wrt_en) begin
      if (bus.flush || load_use) begin
        valid_q   <= 1'b0;
        ctrl_q    <= '0;
        illegal_q <= 1'b0;
      end else begin
        pc_q      <= bus.PCin;
        rs1_q     <= rdata[0];
        rs2_q     <= rdata[1];
        imm_q     <= dec.imm;
        rd_q      <= dec.rd;
        alu_q     <= dec.alu_op;
        ctrl_q    <= dec.ctrl;
        valid_q   <= 1'b1;
        illegal_q <= dec.illegal;
      end
    end
  end

  assign bus.PCnext    = pc_q;
  assign bus.rs1_data  = rs1_q;
  assign bus.rs2_data  = rs2_q;
  assign bus.imm       = imm_q;
  assign bus.rd        = rd_q;
  assign bus.alu_op    = alu_q;
  assign bus.ctrl      = ctrl_q;
  assign bus.valid_out = valid_q;
  assign bus.illegal   = illegal_q;

endmodule
